// File: rtl/hgcal_fc_pkg.sv
// Shared fast-control definitions: command codes, command indices and orbit length.
// Used by both the send encoder and the decoder side.
package hgcal_fc_pkg;

  localparam int unsigned NumCmds = 6;

  // Bit positions in the pending/request vectors; higher index wins arbitration.
  localparam int unsigned IdxL1A       = 0;
  localparam int unsigned IdxCalL1A    = 1;
  localparam int unsigned IdxCalReq    = 2;
  localparam int unsigned IdxOrbitSync = 3;
  localparam int unsigned IdxOcr       = 4;
  localparam int unsigned IdxLinkReset = 5;

  localparam logic [7:0] CodeIdle      = 8'hAC;
  localparam logic [7:0] CodeL1A       = 8'h4B;
  localparam logic [7:0] CodeOrbitSync = 8'h2D;
  localparam logic [7:0] CodeOcr       = 8'h33;
  localparam logic [7:0] CodeCalReq    = 8'h1E;
  localparam logic [7:0] CodeCalL1A    = 8'h55;
  localparam logic [7:0] CodeLinkReset = 8'h69;

  localparam int unsigned ORBIT_LEN = 3564;

  function automatic logic [7:0] cmd_code(input int idx);
    logic [7:0] code;
    unique case (idx)
      IdxL1A:       code = CodeL1A;
      IdxCalL1A:    code = CodeCalL1A;
      IdxCalReq:    code = CodeCalReq;
      IdxOrbitSync: code = CodeOrbitSync;
      IdxOcr:       code = CodeOcr;
      IdxLinkReset: code = CodeLinkReset;
      default:      code = CodeIdle;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hgcal_fc_cmd_arbiter.sv
// Fixed-priority command selector: highest set index wins, IDLE code when nothing is requested.
module hgcal_fc_cmd_arbiter
  import hgcal_fc_pkg::*;
(
  input  logic [NumCmds-1:0] req_i,
  output logic [NumCmds-1:0] grant_o,
  output logic [7:0]         code_o
);

  always_comb begin
    grant_o = '0;
    code_o  = CodeIdle;
    // Ascending scan so the last (highest-priority) hit overrides earlier ones.
    for (int i = 0; i < NumCmds; i++) begin
      if (req_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        code_o     = cmd_code(i);
      end
    end
  end

endmodule

// File: rtl/hgcal_fc_send_encoder.sv
// Fast-control serial encoder: one 8-bit command word per BX, MSB first, on gclk320.
// Optional internal OrbitSync generator enabled by defining FC_TX_ORBIT_GEN_EN.
module hgcal_fc_send_encoder
  import hgcal_fc_pkg::*;
(
  input  logic        gclk320,
  input  logic        n_rstExt,
  input  logic        req_LinkReset,
  input  logic        req_OrbitCountReset_OrbitSync,
  input  logic        req_OrbitSync,
  input  logic        req_CalibrationReq,
  input  logic        req_CalibrationL1A,
  input  logic        req_L1A,
  output logic        fc_stream,
  output logic        gclk40,
  output logic        bx_strobe,
  output logic [5:0]  pending,
  output logic [15:0] drop_count
);

  logic [2:0]         phase_q, phase_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               gclk40_q, gclk40_d;
  logic               bx_strobe_q, bx_strobe_d;
  logic [NumCmds-1:0] pending_q, pending_d;
  logic [NumCmds-1:0] ext_req, orbit_req, req_vec, arb_req, arb_grant, grant, dropped;
  logic [7:0]         arb_code;
  logic [15:0]        drop_q, drop_d;
  logic [2:0]         drop_inc;
  logic [16:0]        drop_sum;
  logic               load;

  assign ext_req = {req_LinkReset, req_OrbitCountReset_OrbitSync, req_OrbitSync,
                    req_CalibrationReq, req_CalibrationL1A, req_L1A};
  assign load    = (phase_q == 3'd7);

`ifdef FC_TX_ORBIT_GEN_EN
  logic [11:0] bx_cnt_q, bx_cnt_d;

  always_comb begin
    orbit_req               = '0;
    orbit_req[IdxOrbitSync] = load && (bx_cnt_q == 12'(ORBIT_LEN - 1));
    bx_cnt_d                = bx_cnt_q;
    if (load) begin
      if (grant[IdxOcr] || (bx_cnt_q == 12'(ORBIT_LEN - 1))) begin
        bx_cnt_d = '0;
      end else begin
        bx_cnt_d = bx_cnt_q + 12'd1;
      end
    end
  end

  always_ff @(posedge gclk320 or negedge n_rstExt) begin
    if (!n_rstExt) begin
      bx_cnt_q <= '0;
    end else begin
      bx_cnt_q <= bx_cnt_d;
    end
  end
`else
  assign orbit_req = '0;
`endif

  assign req_vec = ext_req | orbit_req;
  assign arb_req = pending_q | req_vec;

  hgcal_fc_cmd_arbiter u_arbiter (
    .req_i   (arb_req),
    .grant_o (arb_grant),
    .code_o  (arb_code)
  );

  // Only the load cycle consumes a command; otherwise everything stays pending.
  assign grant = load ? arb_grant : '0;

  always_comb begin
    phase_d     = phase_q + 3'd1;
    gclk40_d    = ~phase_d[2];
    bx_strobe_d = (phase_d == 3'd7);
    shreg_d     = load ? arb_code : {shreg_q[6:0], 1'b0};
    pending_d   = arb_req & ~grant;
    dropped     = req_vec & pending_q & ~grant;
    drop_inc    = '0;
    for (int i = 0; i < NumCmds; i++) begin
      drop_inc = drop_inc + 3'(dropped[i]);
    end
    drop_sum = {1'b0, drop_q} + {14'd0, drop_inc};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge gclk320 or negedge n_rstExt) begin
    if (!n_rstExt) begin
      phase_q     <= 3'd7;
      shreg_q     <= '0;
      gclk40_q    <= 1'b0;
      bx_strobe_q <= 1'b0;
      pending_q   <= '0;
      drop_q      <= '0;
    end else begin
      phase_q     <= phase_d;
      shreg_q     <= shreg_d;
      gclk40_q    <= gclk40_d;
      bx_strobe_q <= bx_strobe_d;
      pending_q   <= pending_d;
      drop_q      <= drop_d;
    end
  end

  assign fc_stream  = shreg_q[7];
  assign gclk40     = gclk40_q;
  assign bx_strobe  = bx_strobe_q;
  assign pending    = pending_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_hgcal_fc_send_encoder.sv
// Self-checking bench for hgcal_fc_send_encoder: vector table, hand sequences and random traffic
// compared cycle by cycle against a behavioural model of the fast-control send rules.
module tb_hgcal_fc_send_encoder;

  logic        gclk320 = 1'b0;
  logic        n_rstExt = 1'b0;
  logic [5:0]  req = '0;
  logic        fc_stream, gclk40, bx_strobe;
  logic [5:0]  pending;
  logic [15:0] drop_count;

  always #5 gclk320 = ~gclk320;

  hgcal_fc_send_encoder dut (
    .gclk320                       (gclk320),
    .n_rstExt                      (n_rstExt),
    .req_LinkReset                 (req[5]),
    .req_OrbitCountReset_OrbitSync (req[4]),
    .req_OrbitSync                 (req[3]),
    .req_CalibrationReq            (req[2]),
    .req_CalibrationL1A            (req[1]),
    .req_L1A                       (req[0]),
    .fc_stream                     (fc_stream),
    .gclk40                        (gclk40),
    .bx_strobe                     (bx_strobe),
    .pending                       (pending),
    .drop_count                    (drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: bit-time within the BX, pending set, drop tally, expected serial bits.
  int       m_phase;
  bit [5:0] m_pend;
  int       m_drops;
  int       m_bx;
  bit       exp_q[$];
  bit [7:0] codes [6] = '{8'h4B, 8'h55, 8'h1E, 8'h2D, 8'h33, 8'h69};

  typedef struct {
    logic [5:0] req;
    int         ph;
    logic [5:0] pend_req;
    logic [5:0] pend_load;
    logic [7:0] w1;
    logic [7:0] w2;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit [5:0] r);
    bit       load = (m_phase == 7);
    int       pick = -1;
    bit [5:0] rr = r;
    bit [7:0] word;
`ifdef FC_TX_ORBIT_GEN_EN
    if (load && m_bx == 3563) rr[3] = 1'b1;
`endif
    if (load) begin
      for (int i = 5; i >= 0; i--) if ((m_pend[i] || rr[i]) && pick < 0) pick = i;
      word = (pick < 0) ? 8'hAC : codes[pick];
      for (int b = 7; b >= 0; b--) exp_q.push_back(word[b]);
`ifdef FC_TX_ORBIT_GEN_EN
      m_bx = (pick == 4 || m_bx == 3563) ? 0 : m_bx + 1;
`endif
    end
    for (int i = 0; i < 6; i++) begin
      if (rr[i] && m_pend[i] && i != pick && m_drops < 65535) m_drops++;
      m_pend[i] = (m_pend[i] || rr[i]) && (i != pick);
    end
    m_phase = (m_phase + 1) % 8;
  endtask

  task automatic tick(input bit [5:0] r);
    bit eb;
    req = r;
    @(posedge gclk320);
    #1;
    req = '0;
    model_step(r);
    eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
    check("fc_stream", 32'(fc_stream), 32'(eb));
    check("gclk40", 32'(gclk40), 32'(m_phase < 4));
    check("bx_strobe", 32'(bx_strobe), 32'(m_phase == 7));
    check("pending", 32'(pending), 32'(m_pend));
    check("drop_count", 32'(drop_count), 32'(m_drops));
  endtask

  task automatic do_reset();
    n_rstExt = 1'b0;
    req = 6'h3F;
    repeat (2) @(posedge gclk320);
    #1;
    check("rst_fc_stream", 32'(fc_stream), 32'd0);
    check("rst_gclk40", 32'(gclk40), 32'd0);
    check("rst_bx_strobe", 32'(bx_strobe), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    req = '0;
    n_rstExt = 1'b1;
    m_phase = 7;
    m_pend = '0;
    m_drops = 0;
    m_bx = 0;
    exp_q.delete();
  endtask

  // Called just after a load edge: bit 7 is already on the line.
  task automatic collect(output logic [7:0] w);
    w[7] = fc_stream;
    for (int b = 6; b >= 0; b--) begin
      tick(6'd0);
      w[b] = fc_stream;
    end
  endtask

  task automatic next_word(output logic [7:0] w);
    tick(6'd0);
    collect(w);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] w;
    do_reset();
    for (int k = 0; k < 8 && m_phase != v.ph; k++) tick(6'd0);
    tick(v.req);
    check($sformatf("v%0d_pend_req", idx), 32'(pending), 32'(v.pend_req));
    if (v.ph != 7) begin
      for (int k = 0; k < 8 && m_phase != 7; k++) tick(6'd0);
      tick(6'd0);
    end
    check($sformatf("v%0d_pend_load", idx), 32'(pending), 32'(v.pend_load));
    collect(w);
    check($sformatf("v%0d_word1", idx), 32'(w), 32'(v.w1));
    next_word(w);
    check($sformatf("v%0d_word2", idx), 32'(w), 32'(v.w2));
    check($sformatf("v%0d_drops", idx), 32'(drop_count), 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    int         hits;
    int         hit_at;

    vecs[0] = '{6'b000001, 3, 6'b000001, 6'b000000, 8'h4B, 8'hAC};
    vecs[1] = '{6'b100001, 2, 6'b100001, 6'b000001, 8'h69, 8'h4B};
    vecs[2] = '{6'b010000, 7, 6'b000000, 6'b000000, 8'h33, 8'hAC};
    vecs[3] = '{6'b001110, 0, 6'b001110, 6'b000110, 8'h2D, 8'h1E};
    vecs[4] = '{6'b000010, 5, 6'b000010, 6'b000000, 8'h55, 8'hAC};
    vecs[5] = '{6'b111111, 1, 6'b111111, 6'b011111, 8'h69, 8'h33};
    vecs[6] = '{6'b000001, 7, 6'b000000, 6'b000000, 8'h4B, 8'hAC};
    vecs[7] = '{6'b100010, 7, 6'b000010, 6'b000010, 8'h69, 8'h55};

    // Idle stream after reset: first edge loads IDLE and raises gclk40.
    do_reset();
    tick(6'd0);
    check("first_gclk40", 32'(gclk40), 32'd1);
    check("first_bit", 32'(fc_stream), 32'd1);
    collect(w);
    check("idle_word0", 32'(w), 32'hAC);
    for (int k = 1; k < 4; k++) begin
      next_word(w);
      check($sformatf("idle_word%0d", k), 32'(w), 32'hAC);
    end

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Two CalReq pulses in one BX: one word sent, one drop.
    do_reset();
    for (int k = 0; k < 8 && m_phase != 1; k++) tick(6'd0);
    tick(6'b000100);
    for (int k = 0; k < 8 && m_phase != 4; k++) tick(6'd0);
    tick(6'b000100);
    check("calreq_drop", 32'(drop_count), 32'd1);
    for (int k = 0; k < 8 && m_phase != 7; k++) tick(6'd0);
    next_word(w);
    check("calreq_word", 32'(w), 32'h1E);
    next_word(w);
    check("calreq_after", 32'(w), 32'hAC);
    check("calreq_drop_end", 32'(drop_count), 32'd1);

    // Random traffic with one asynchronous reset in the middle of a word.
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      if (k == 1000) begin
        @(posedge gclk320);
        #3;
        n_rstExt = 1'b0;
        #1;
        check("async_fc_stream", 32'(fc_stream), 32'd0);
        check("async_pending", 32'(pending), 32'd0);
        do_reset();
      end
      if ($urandom_range(0, 3) == 0) tick(6'($urandom) & 6'($urandom));
      else tick(6'd0);
    end

    // Saturation: every request held high keeps colliding.
    do_reset();
    repeat (12500) tick(6'h3F);
    check("sat_drop", 32'(drop_count), 32'hFFFF);
    repeat (20) tick(6'h3F);
    check("sat_hold", 32'(drop_count), 32'hFFFF);

`ifdef FC_TX_ORBIT_GEN_EN
    do_reset();
    tick(6'd0);
    collect(w);
    hits = 0;
    hit_at = -1;
    for (int k = 1; k <= 3564; k++) begin
      next_word(w);
      if (w == 8'h2D) begin
        hits++;
        hit_at = k;
      end
    end
    check("orbit_hits", 32'(hits), 32'd1);
    check("orbit_pos", 32'(hit_at), 32'd3563);
    tick(6'b010000);
    collect(w);
    check("ocr_word", 32'(w), 32'h33);
    hits = 0;
    hit_at = -1;
    for (int k = 1; k <= 3565; k++) begin
      next_word(w);
      if (w == 8'h2D) begin
        hits++;
        hit_at = k;
      end
    end
    check("ocr_orbit_hits", 32'(hits), 32'd1);
    check("ocr_orbit_pos", 32'(hit_at), 32'd3564);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
